wb_slave_mem: RTL and testbench



---
 rtl/wb_slave_mem_pkg.sv | 23 ++
 rtl/wb_slave_mem_if.sv | 25 ++
 rtl/wb_slave_mem_ram.sv | 27 ++
 rtl/wb_slave_mem.sv | 119 +++++++++++
 tb/tb_wb_slave_mem.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_slave_mem_pkg.sv
// Shared Wishbone widths, responder FSM states and the address-window helper.
package wb_slave_pkg;

    localparam int WB_AW   = 32;
    localparam int WB_DW   = 32;
    localparam int WB_SELW = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } wb_slv_state_e;

    // Shifting before the compare keeps a full 4 GiB window from overflowing depth*4.
    function automatic logic in_window(input logic [WB_AW-1:0] adr,
                                       input logic [WB_AW-1:0] base,
                                       input int unsigned      depth);
        logic [WB_AW-1:0] offset;
        offset = adr - base;
        return (adr >= base) && ((offset >> 2) < WB_AW'(depth));
    endfunction

endpackage

// File: rtl/wb_slave_mem_if.sv
// Wishbone B4 classic bus bundle between one master and the memory responder.
interface wb_slave_mem_if;
    import wb_slave_pkg::*;

    logic               wb_cyc_i;
    logic               wb_stb_i;
    logic               wb_we_i;
    logic [WB_AW-1:0]   wb_adr_i;
    logic [WB_DW-1:0]   wb_dat_i;
    logic [WB_SELW-1:0] wb_sel_i;
    logic [WB_DW-1:0]   wb_dat_o;
    logic               wb_ack_o;
    logic               wb_err_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );

endinterface

// File: rtl/wb_slave_mem_ram.sv
// Word-indexed storage with per-byte write enables and an asynchronous read port.
module wb_slave_mem_ram
    import wb_slave_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int          IW    = $clog2(DEPTH)
) (
    input  logic               i_clk,
    input  logic [WB_SELW-1:0] i_be,
    input  logic [IW-1:0]      i_idx,
    input  logic [WB_DW-1:0]   i_wdata,
    output logic [WB_DW-1:0]   o_rdata
);

    logic [WB_DW-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < WB_SELW; b++) begin
            if (i_be[b]) begin
                r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/wb_slave_mem.sv
// Wishbone B4 classic responder over a byte-enabled RAM with programmable wait states.
// Define WB_SLAVE_MEM_ERR_EN to terminate out-of-window or misaligned requests with err.
module wb_slave_mem
    import wb_slave_pkg::*;
#(
    parameter int unsigned      DEPTH       = 256,
    parameter logic [WB_AW-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned      WAIT_STATES = 0
) (
    input logic           clk,
    input logic           rst,
    wb_slave_mem_if.slave bus
);

    localparam int         IW      = $clog2(DEPTH);
    localparam logic [3:0] WS_LAST = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    wb_slv_state_e      r_state;
    wb_slv_state_e      w_next;
    logic [3:0]         r_cnt;
    logic [3:0]         w_cntNext;
    logic [WB_AW-1:0]   r_adr;
    logic [WB_DW-1:0]   r_dat;
    logic [WB_SELW-1:0] r_sel;
    logic               r_we;

    logic               w_req;
    logic               w_resp;
    logic               w_inWin;
    logic               w_ack;
    logic               w_err;
    logic [IW-1:0]      w_idx;
    logic [WB_SELW-1:0] w_be;
    logic [WB_DW-1:0]   w_rdata;

    assign w_req   = bus.wb_cyc_i & bus.wb_stb_i;
    assign w_inWin = in_window(r_adr, BASE_ADDR, DEPTH);
    assign w_idx   = IW'((r_adr - BASE_ADDR) >> 2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_sel   <= '0;
            r_we    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cntNext;
            if (r_state == IDLE && w_req) begin
                r_adr <= bus.wb_adr_i;
                r_dat <= bus.wb_dat_i;
                r_sel <= bus.wb_sel_i;
                r_we  <= bus.wb_we_i;
            end
        end
    end

    // The response only fires while the master still holds cyc&stb, so a late drop aborts it.
    always_comb begin
        w_next    = r_state;
        w_cntNext = r_cnt;
        w_resp    = 1'b0;
        case (r_state)
            IDLE: begin
                w_cntNext = '0;
                if (w_req) begin
                    w_next = (WAIT_STATES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (!w_req) begin
                    w_next    = IDLE;
                    w_cntNext = '0;
                end else if (r_cnt == WS_LAST) begin
                    w_next    = RESP;
                    w_cntNext = '0;
                end else begin
                    w_cntNext = r_cnt + 4'd1;
                end
            end
            RESP: begin
                w_next = IDLE;
                w_resp = w_req & ~rst;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

`ifdef WB_SLAVE_MEM_ERR_EN
    logic w_bad;
    assign w_bad = ~w_inWin | (r_adr[1:0] != 2'b00);
    assign w_ack = w_resp & ~w_bad;
    assign w_err = w_resp & w_bad;
`else
    assign w_ack = w_resp;
    assign w_err = 1'b0;
`endif

    assign w_be = (w_ack && r_we && w_inWin) ? r_sel : '0;

    wb_slave_mem_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .i_clk   (clk),
        .i_be    (w_be),
        .i_idx   (w_idx),
        .i_wdata (r_dat),
        .o_rdata (w_rdata)
    );

    assign bus.wb_ack_o = w_ack;
    assign bus.wb_err_o = w_err;
    assign bus.wb_dat_o = (w_ack && !r_we && w_inWin) ? w_rdata : '0;

endmodule

// File: tb/tb_wb_slave_mem.sv
// Scoreboard bench for wb_slave_mem: three instances with 0, 3 and 5 wait states share one master.
// Honours WB_SLAVE_MEM_ERR_EN for the out-of-window and misaligned expectations.
module tb_wb_slave_mem;
    import wb_slave_pkg::*;

    typedef struct {
        string       tag;
        bit          ack;
        bit          err;
        logic [31:0] dat;
        bit          chkDat;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [2:0]  cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;

    int          nComp;
    int          nFail;
    exp_t        sbq[$];
    logic [31:0] model [3][256];

    localparam int          WS0 = 0, WS1 = 3, WS2 = 5;
    localparam logic [31:0] BASE0 = 32'h0000_0000;
    localparam logic [31:0] BASE2 = 32'h0000_2000;

    wb_slave_mem_if ifc0 ();
    wb_slave_mem_if ifc1 ();
    wb_slave_mem_if ifc2 ();

    assign ifc0.wb_cyc_i = cyc[0];
    assign ifc1.wb_cyc_i = cyc[1];
    assign ifc2.wb_cyc_i = cyc[2];
    assign ifc0.wb_stb_i = stb;
    assign ifc1.wb_stb_i = stb;
    assign ifc2.wb_stb_i = stb;
    assign ifc0.wb_we_i  = we;
    assign ifc1.wb_we_i  = we;
    assign ifc2.wb_we_i  = we;
    assign ifc0.wb_adr_i = adr;
    assign ifc1.wb_adr_i = adr;
    assign ifc2.wb_adr_i = adr;
    assign ifc0.wb_dat_i = wdat;
    assign ifc1.wb_dat_i = wdat;
    assign ifc2.wb_dat_i = wdat;
    assign ifc0.wb_sel_i = sel;
    assign ifc1.wb_sel_i = sel;
    assign ifc2.wb_sel_i = sel;

    wb_slave_mem #(.DEPTH(256), .BASE_ADDR(BASE0), .WAIT_STATES(WS0))
        u_dut0 (.clk(clk), .rst(rst), .bus(ifc0));
    wb_slave_mem #(.DEPTH(256), .BASE_ADDR(BASE0), .WAIT_STATES(WS1))
        u_dut1 (.clk(clk), .rst(rst), .bus(ifc1));
    wb_slave_mem #(.DEPTH(256), .BASE_ADDR(BASE2), .WAIT_STATES(WS2))
        u_dut2 (.clk(clk), .rst(rst), .bus(ifc2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wsOf(input int d);
        return (d == 0) ? WS0 : (d == 1) ? WS1 : WS2;
    endfunction

    function automatic logic [31:0] baseOf(input int d);
        return (d == 2) ? BASE2 : BASE0;
    endfunction

    function automatic logic getAck(input int d);
        return (d == 0) ? ifc0.wb_ack_o : (d == 1) ? ifc1.wb_ack_o : ifc2.wb_ack_o;
    endfunction

    function automatic logic getErr(input int d);
        return (d == 0) ? ifc0.wb_err_o : (d == 1) ? ifc1.wb_err_o : ifc2.wb_err_o;
    endfunction

    function automatic logic [31:0] getDat(input int d);
        return (d == 0) ? ifc0.wb_dat_o : (d == 1) ? ifc1.wb_dat_o : ifc2.wb_dat_o;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nComp++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Builds the expectation from an independent byte-lane model, then runs one classic cycle.
    task automatic applyStimulus(input int d, input bit isWr, input logic [31:0] a,
                                 input logic [31:0] dv, input logic [3:0] sv, input string tag);
        exp_t        e;
        exp_t        got;
        logic [31:0] off;
        bit          inWin;
        bit          bad;
        bit          seen;
        int          lat;
        int          idx;
        off   = a - baseOf(d);
        inWin = (a >= baseOf(d)) && ((off >> 2) < 32'd256);
        idx   = int'(off >> 2) & 255;
        bad   = !inWin;
`ifdef WB_SLAVE_MEM_ERR_EN
        bad   = bad || (a[1:0] != 2'b00);
        e.ack = !bad;
        e.err = bad;
`else
        e.ack = 1'b1;
        e.err = 1'b0;
`endif
        e.tag    = tag;
        e.lat    = wsOf(d) + 1;
        e.chkDat = !isWr;
        e.dat    = (inWin && e.ack) ? model[d][idx] : 32'h0;
        if (isWr && e.ack && inWin) begin
            for (int b = 0; b < 4; b++) begin
                if (sv[b]) model[d][idx][8*b +: 8] = dv[8*b +: 8];
            end
        end
        sbq.push_back(e);

        cyc[d] = 1'b1;
        stb    = 1'b1;
        we     = isWr;
        adr    = a;
        wdat   = dv;
        sel    = sv;
        seen   = 1'b0;
        lat    = 0;
        while (!seen && lat < wsOf(d) + 4) begin
            @(posedge clk);
            #1;
            lat++;
            if (getAck(d) || getErr(d)) seen = 1'b1;
            else if (!isWr) checkOutput({tag, " dat before ack"}, getDat(d), 32'h0);
        end
        got = sbq.pop_front();
        checkOutput({got.tag, " response seen"}, 32'(seen), 32'd1);
        if (seen) begin
            checkOutput({got.tag, " latency"}, 32'(lat), 32'(got.lat));
            checkOutput({got.tag, " ack"}, 32'(getAck(d)), 32'(got.ack));
            checkOutput({got.tag, " err"}, 32'(getErr(d)), 32'(got.err));
            if (got.chkDat) checkOutput({got.tag, " rdata"}, getDat(d), got.dat);
            @(posedge clk);
            #1;
            checkOutput({got.tag, " single-cycle term"}, 32'(getAck(d) | getErr(d)), 32'd0);
        end
        cyc[d] = 1'b0;
        stb    = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic doAbort(input int d, input logic [31:0] a, input logic [31:0] dv, input int dropAfter);
        bit seen;
        cyc[d] = 1'b1;
        stb    = 1'b1;
        we     = 1'b1;
        adr    = a;
        wdat   = dv;
        sel    = 4'hF;
        seen   = 1'b0;
        repeat (dropAfter) begin
            @(posedge clk);
            #1;
            if (getAck(d) || getErr(d)) seen = 1'b1;
        end
        cyc[d] = 1'b0;
        repeat (wsOf(d) + 3) begin
            @(posedge clk);
            #1;
            if (getAck(d) || getErr(d)) seen = 1'b1;
        end
        stb = 1'b0;
        checkOutput("abort no termination", 32'(seen), 32'd0);
    endtask

    initial begin
        nComp = 0;
        nFail = 0;
        rst   = 1'b1;
        cyc   = '0;
        stb   = 1'b0;
        we    = 1'b0;
        adr   = '0;
        wdat  = '0;
        sel   = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("reset ack dut%0d", d), 32'(getAck(d)), 32'd0);
            checkOutput($sformatf("reset err dut%0d", d), 32'(getErr(d)), 32'd0);
            checkOutput($sformatf("reset dat dut%0d", d), getDat(d), 32'h0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, "ws0 write 0x10");
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'hF, "ws0 read 0x10");
        applyStimulus(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF, "prefill 0x20");
        applyStimulus(0, 1'b1, 32'h20, 32'h1122_3344, 4'b0101, "lane write 0x20");
        applyStimulus(0, 1'b0, 32'h20, 32'h0, 4'h0, "lane read 0x20");
        applyStimulus(0, 1'b1, 32'h20, 32'h0, 4'h0, "sel0 write 0x20");
        applyStimulus(0, 1'b0, 32'h20, 32'h0, 4'hF, "sel0 read 0x20");

        applyStimulus(1, 1'b1, 32'h0, 32'h1234_5678, 4'hF, "ws3 write 0x0");
        applyStimulus(1, 1'b0, 32'h0, 32'h0, 4'hF, "ws3 read 0x0");

        applyStimulus(2, 1'b1, BASE2 + 32'h30, 32'hAAAA_5555, 4'hF, "ws5 write 0x30");
        doAbort(2, BASE2 + 32'h30, 32'h0000_0000, 2);
        applyStimulus(2, 1'b0, BASE2 + 32'h30, 32'h0, 4'hF, "read after abort");

        applyStimulus(2, 1'b1, BASE2 + 32'h40, 32'hCAFE_F00D, 4'hF, "ws5 write 0x40");
        cyc[2] = 1'b1;
        stb    = 1'b1;
        we     = 1'b1;
        adr    = BASE2 + 32'h40;
        wdat   = 32'h0;
        sel    = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst in wait ack", 32'(getAck(2)), 32'd0);
        checkOutput("rst in wait err", 32'(getErr(2)), 32'd0);
        checkOutput("rst in wait state", 32'(u_dut2.r_state), 32'(IDLE));
        rst    = 1'b0;
        cyc[2] = 1'b0;
        stb    = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(2, 1'b0, BASE2 + 32'h40, 32'h0, 4'hF, "read after reset");

        applyStimulus(0, 1'b1, 32'h0, 32'h0BAD_F00D, 4'hF, "ws0 write 0x0");
        applyStimulus(0, 1'b0, 32'h400, 32'h0, 4'hF, "out of range read");
        applyStimulus(0, 1'b1, 32'h400, 32'h0000_0001, 4'hF, "out of range write");
        applyStimulus(0, 1'b0, 32'h0, 32'h0, 4'hF, "read 0x0 after oor write");
        applyStimulus(2, 1'b0, BASE2 - 32'h4, 32'h0, 4'hF, "below base read");
        applyStimulus(0, 1'b0, 32'h11, 32'h0, 4'hF, "misaligned read");

        checkOutput("scoreboard drained", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nFail);
        $finish;
    end

endmodule
